muldiv_sequencer: RTL and testbench

- Controls an iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
- Accepts one M-extension op from the ID/EX latch, stalls the pipeline while it iterates, and holds the result until the EX/MEM latch loads it.
- Handles kills from a branch or jump redirect and the RISC-V special cases: divide-by-zero and signed overflow.

---
 rtl/muldiv_sequencer.sv | 172 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer. It sits beside the EX-stage ALU.
// One M-extension op is accepted from ID/EX. The pipeline is stalled while the
// shift-add or restoring-divide datapath iterates. The result is then held
// until the EX/MEM latch takes it.
module muldiv_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1     // 1, 2 or 4
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             advance,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(N - 1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_reg, state_next;

    logic [2:0]         op_reg;
    logic               neg_reg;      // final result must be negated
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;      // mul: {hi, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_reg;     // mul: |a| multiplicand; div: |b| divisor
    logic [WIDTH-1:0]   result_reg;

    // ---------------- incoming op decode (used only on IDLE acceptance) ----
    logic             is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             div_zero, div_ovf, special_in;
    logic [WIDTH-1:0] special_result;
    logic             accept, calc_step;

    assign is_div_in   = funct3[2];
    // Signed operands: MULH both, MULHSU rs1 only, DIV/REM both.
    assign a_signed_in = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign b_signed_in = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign a_neg_in    = a_signed_in & a[WIDTH-1];
    assign b_neg_in    = b_signed_in & b[WIDTH-1];
    assign abs_a       = a_neg_in ? (~a + 1'b1) : a;
    assign abs_b       = b_neg_in ? (~b + 1'b1) : b;
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    assign neg_in      = (is_div_in && funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

    assign div_zero    = is_div_in && (b == '0);
    assign div_ovf     = is_div_in && !funct3[0] && (a == MIN_INT) && (b == '1);
    assign special_in  = div_zero || div_ovf;
    assign special_result = div_zero ? (funct3[1] ? a : '1)
                                     : (funct3[1] ? '0 : MIN_INT);

    assign accept    = (state_reg == IDLE) && start && !flush;
    assign calc_step = (state_reg == CALC) && !flush;

    // ---------------- iteration datapath: BITS_PER_CYCLE chained steps -----
    logic [BITS_PER_CYCLE:0][2*WIDTH-1:0] stage;
    assign stage[0] = acc_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [WIDTH:0] mul_sum;
            logic [WIDTH:0] div_trial;
            logic [WIDTH:0] div_diff;

            // Shift-add: conditionally add multiplicand to the high half, then shift right.
            assign mul_sum   = {1'b0, stage[gi][2*WIDTH-1:WIDTH]}
                             + (stage[gi][0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
            // Restoring divide: shift in the next dividend bit and try a subtract.
            assign div_trial = {stage[gi][2*WIDTH-1:WIDTH], stage[gi][WIDTH-1]};
            assign div_diff  = div_trial - {1'b0, opnd_reg};

            assign stage[gi+1] = op_reg[2]
                ? (div_diff[WIDTH] ? {div_trial[WIDTH-1:0], stage[gi][WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0],  stage[gi][WIDTH-2:0], 1'b1})
                : {mul_sum, stage[gi][WIDTH-1:1]};
        end
    endgenerate

    // ---------------- final sign correction and result selection -----------
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_raw, rem_raw, final_result;

    assign prod_fixed = neg_reg ? (~stage[BITS_PER_CYCLE] + 1'b1) : stage[BITS_PER_CYCLE];
    assign quo_raw    = stage[BITS_PER_CYCLE][WIDTH-1:0];
    assign rem_raw    = stage[BITS_PER_CYCLE][2*WIDTH-1:WIDTH];

    // Pick the low/high product half, quotient or remainder for the latched op.
    always_comb begin
        final_result = prod_fixed[WIDTH-1:0];
        case (op_reg)
            3'd0:         final_result = prod_fixed[WIDTH-1:0];
            3'd1, 3'd2,
            3'd3:         final_result = prod_fixed[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:   final_result = neg_reg ? (~quo_raw + 1'b1) : quo_raw;
            default:      final_result = neg_reg ? (~rem_raw + 1'b1) : rem_raw;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state and stall/done decode; flush overrides every transition.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    stall      = 1'b1;
                    state_next = special_in ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (cnt_reg == '0) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (advance) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
        // The pipeline is never frozen while reset is held.
        stall = stall & rst;
    end

    // Operand latch on acceptance, one iteration per CALC cycle, result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
        end else if (accept) begin
            op_reg  <= funct3;
            neg_reg <= neg_in;
            cnt_reg <= CNT_LOAD;
            if (is_div_in) begin
                acc_reg  <= {{WIDTH{1'b0}}, abs_a};
                opnd_reg <= abs_b;
            end else begin
                acc_reg  <= {{WIDTH{1'b0}}, abs_b};
                opnd_reg <= abs_a;
            end
            if (special_in) result_reg <= special_result;
        end else if (calc_step) begin
            acc_reg <= stage[BITS_PER_CYCLE];
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) result_reg <= final_result;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer. It applies a directed vector table, then
// hand-written flush/hold/reset sequences, then randomized ops. Results are
// checked against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start, flush, advance;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .advance (advance),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // RV32M semantics computed directly with 64-bit and native signed arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          xi, yi;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        xi = $signed(x);
        yi = $signed(y);
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN_INT && y == 32'hFFFF_FFFF) return x;
                return 32'(xi / yi);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN_INT && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(xi % yi);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == MIN_INT && y == 32'hFFFF_FFFF))) return 1;
        return W + 1;
    endfunction

    // Issue one op at the next cycle and wait for done. Check the result, the
    // latency and the stall count. Optionally hold DONE (with start noise),
    // then advance.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int   cyc;
        int   stall_cnt;
        logic got_done;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; a = x; b = y;
        @(negedge clk);
        stall_cnt = stall ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
        cyc = 1;
        got_done = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (stall) stall_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!got_done) begin
            chk({tag, " done timeout"}, {31'b0, done}, 32'd1);
            return;
        end
        $display("%s f=%0d a=%h b=%h result=%h cycles=%0d", tag, f, x, y, result, cyc);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " stall cycles"}, stall_cnt, exp_lat);
        chk({tag, " stall in done"}, {31'b0, stall}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            start = 1'b1; funct3 = 3'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, " hold done"}, {31'b0, done}, 32'd1);
            chk({tag, " hold result"}, result, exp_res);
            chk({tag, " hold stall"}, {31'b0, stall}, 32'd0);
        end
        start = 1'b0;
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0;
        @(negedge clk);
        chk({tag, " done after advance"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen_done;
        logic [2:0]  rf;
        logic [31:0] rx, ry;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[3]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[4]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[5]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[6]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[7]  = '{3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33};
        vecs[8]  = '{3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33};
        vecs[9]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[10] = '{3'd0, 32'h1234_5678,  32'd0,         32'd0,         33};
        vecs[11] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[12] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};

        rst = 1'b0; start = 1'b1; flush = 1'b0; advance = 1'b0;
        funct3 = 3'd0; a = 32'd0; b = 32'd0;
        #12;
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Directed table; entry 2 also exercises a 3-cycle DONE hold.
        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].x, vecs[i].y,
                   vecs[i].exp, vecs[i].lat, (i == 2) ? 3 : 0);

        // flush together with start in IDLE: the op must not be accepted.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        chk("flush+start stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush+start idle stall", {31'b0, stall}, 32'd0);
        chk("flush+start idle done", {31'b0, done}, 32'd0);

        // Flush at T0+10 during CALC, then DIVU 100/7 starting at T0+12.
        seen_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush cycle stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("after flush stall", {31'b0, stall}, 32'd0);
        chk("after flush done", {31'b0, done}, 32'd0);
        chk("done never seen before flush", {31'b0, seen_done}, 32'd0);
        $display("flush at T0+10 applied");
        run_op("divu after flush", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);

        // Asynchronous reset pulse mid-CALC, away from any clock edge.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("calc stall before reset", {31'b0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async reset done", {31'b0, done}, 32'd0);
        chk("async reset stall", {31'b0, stall}, 32'd0);
        chk("async reset result", result, 32'd0);
        #3;
        rst = 1'b1;
        $display("async reset pulse applied mid-calc");
        run_op("mulhu after reset", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

        // Randomized ops with biased corner operands.
        for (int n = 0; n < 150; n++) begin
            rf = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = MIN_INT; ry = 32'hFFFF_FFFF; end
                2: begin rx = $urandom_range(0, 1000); ry = $urandom_range(1, 50); end
                3: ry = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d", n), rf, rx, ry, ref_result(rf, rx, ry),
                   ref_latency(rf, rx, ry), (n % 37 == 5) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
